// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch request stage; owns the fetch PC, issues sram-like
// requests, resolves redirects and hands fetched instructions to the IW stage.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h1C000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        out_ready,
   output logic        out_valid,
   input  logic        ex_flush,
   input  logic        ertn_flush,
   input  logic        tlb_flush,
   input  logic [31:0] ex_entry,
   input  logic [31:0] era,
   input  logic [31:0] refetch_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata,
   input  logic        iw_pending,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic        inst_valid_out,
   output logic        discard_out,
   output logic        has_exception_out,
   output logic [5:0]  ecode_out,
   output logic [8:0]  esubcode_out
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUED, S_EXC} state_t;
   state_t      state;
   logic [31:0] pc, inst_buf, target, pc_next;
   logic        inst_valid, flush_any, capture, handoff;
   assign flush_any = ex_flush | ertn_flush | tlb_flush | br_taken;
   assign target = ex_flush ? ex_entry : ertn_flush ? era : tlb_flush ? refetch_pc : br_target;
   assign pc_next = pc + 32'd4;
   assign capture = state == S_ISSUED && data_ok && !iw_pending && !inst_valid;
   assign handoff = (state == S_ISSUED || state == S_EXC) && out_ready;
   assign inst_sram_req = state == S_REQ && !flush_any;
   // pc holds RESET_PC during reset, but the outputs must read 0 until release
   assign inst_sram_addr = rst_n ? pc : 32'd0;
   assign PC_out = rst_n ? pc : 32'd0;
   assign out_valid = (state == S_ISSUED || state == S_EXC) && !flush_any;
   assign discard_out = flush_any && ((state == S_REQ && inst_sram_req && addr_ok) ||
                        (state == S_ISSUED && !inst_valid && !(data_ok && !iw_pending)));
   assign inst_out = inst_buf;
   assign inst_valid_out = inst_valid;
   assign has_exception_out = state == S_EXC;
   assign ecode_out = has_exception_out ? 6'h08 : 6'h00;
   assign esubcode_out = 9'h0;
   // a misaligned PC enters S_EXC with inst_valid set and inst_buf zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         inst_buf   <= '0;
         inst_valid <= 1'b0;
      end else if (state == S_IDLE) begin
         state      <= |RESET_PC[1:0] ? S_EXC : S_REQ;
         inst_valid <= |RESET_PC[1:0];
      end else if (flush_any) begin
         pc         <= target;
         state      <= |target[1:0] ? S_EXC : S_REQ;
         inst_buf   <= '0;
         inst_valid <= |target[1:0];
      end else if (handoff) begin
         pc         <= pc_next;
         state      <= |pc_next[1:0] ? S_EXC : S_REQ;
         inst_buf   <= '0;
         inst_valid <= |pc_next[1:0];
      end else if (state == S_REQ && addr_ok) begin
         state <= S_ISSUED;
      end else if (capture) begin
         inst_buf   <= rdata;
         inst_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus a randomized run against a behavioural
// fetch model for if_fetch.
module tb_if_fetch;
   localparam logic [31:0] RPC = 32'h1C000000;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        out_ready, out_valid, ex_flush, ertn_flush, tlb_flush, br_taken;
   logic [31:0] ex_entry, era, refetch_pc, br_target, inst_sram_addr, rdata, PC_out, inst_out;
   logic        inst_sram_req, addr_ok, data_ok, iw_pending, inst_valid_out, discard_out;
   logic        has_exception_out;
   logic [5:0]  ecode_out;
   logic [8:0]  esubcode_out;
   int          tests = 0, fails = 0;

   if_fetch #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .out_ready(out_ready), .out_valid(out_valid),
      .ex_flush(ex_flush), .ertn_flush(ertn_flush), .tlb_flush(tlb_flush),
      .ex_entry(ex_entry), .era(era), .refetch_pc(refetch_pc),
      .br_taken(br_taken), .br_target(br_target),
      .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .iw_pending(iw_pending),
      .PC_out(PC_out), .inst_out(inst_out), .inst_valid_out(inst_valid_out),
      .discard_out(discard_out), .has_exception_out(has_exception_out),
      .ecode_out(ecode_out), .esubcode_out(esubcode_out));

   always #5 clk = ~clk;

   task automatic clr;
      out_ready = 0; ex_flush = 0; ertn_flush = 0; tlb_flush = 0; br_taken = 0;
      ex_entry = 0; era = 0; refetch_pc = 0; br_target = 0;
      addr_ok = 0; data_ok = 0; rdata = 0; iw_pending = 0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clr();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   function automatic logic [127:0] all_out();
      return {inst_sram_req, inst_sram_addr, out_valid, PC_out, inst_out, inst_valid_out,
              discard_out, has_exception_out, ecode_out, esubcode_out};
   endfunction

   task automatic test_reset;
      clr();
      rst_n = 0;
      #13;
      tests++;
      if (all_out() !== 128'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", all_out()); end
      #1 rst_n = 1;
      #1;
      tests++;
      if ({inst_sram_req, PC_out} !== {1'b0, RPC}) begin
         fails++; $display("FAIL reset_release: req/pc %b/%h want 0/%h", inst_sram_req, PC_out, RPC);
      end
   endtask

   task automatic test_first_fetch;
      do_reset();
      addr_ok = 1; out_ready = 1;
      tick();
      tests++;
      if ({inst_sram_req, inst_sram_addr} !== {1'b1, RPC}) begin
         fails++; $display("FAIL first_req: got %b/%h want 1/%h", inst_sram_req, inst_sram_addr, RPC);
      end
      tick();
      addr_ok = 0;
      tests++;
      if ({out_valid, PC_out} !== {1'b1, RPC}) begin
         fails++; $display("FAIL first_valid: got %b/%h want 1/%h", out_valid, PC_out, RPC);
      end
      tick();
      tests++;
      if ({inst_sram_req, inst_sram_addr} !== {1'b1, RPC + 32'd4}) begin
         fails++; $display("FAIL second_req: got %b/%h want 1/%h", inst_sram_req, inst_sram_addr, RPC + 32'd4);
      end
   endtask

   task automatic test_capture;
      do_reset();
      addr_ok = 1;
      tick(); tick();
      addr_ok = 0; data_ok = 1; rdata = 32'h02800421;
      #1;
      tests++;
      if (inst_valid_out !== 1'b0) begin fails++; $display("FAIL pre_capture: got %b want 0", inst_valid_out); end
      tick();
      data_ok = 0; rdata = 32'hDEADBEEF;
      tick();
      tests++;
      if ({out_valid, inst_valid_out, inst_out} !== {2'b11, 32'h02800421}) begin
         fails++; $display("FAIL capture_hold: got %b%b/%h want 11/02800421", out_valid, inst_valid_out, inst_out);
      end
      out_ready = 1;
      tick();
      tests++;
      if ({inst_valid_out, PC_out, inst_sram_req} !== {1'b0, RPC + 32'd4, 1'b1}) begin
         fails++; $display("FAIL capture_handoff: got %b/%h/%b want 0/%h/1", inst_valid_out, PC_out, inst_sram_req, RPC + 32'd4);
      end
   endtask

   task automatic test_branch_discard;
      do_reset();
      addr_ok = 1;
      tick(); tick();
      addr_ok = 0; br_taken = 1; br_target = 32'h1C000100;
      #1;
      tests++;
      if ({discard_out, out_valid} !== 2'b10) begin
         fails++; $display("FAIL br_discard: got %b%b want 10", discard_out, out_valid);
      end
      tick();
      br_taken = 0;
      #1;
      tests++;
      if ({discard_out, inst_sram_req, inst_sram_addr} !== {2'b01, 32'h1C000100}) begin
         fails++; $display("FAIL br_redirect: got %b%b/%h want 01/1c000100", discard_out, inst_sram_req, inst_sram_addr);
      end
   endtask

   task automatic test_flush_priority;
      do_reset();
      addr_ok = 1;
      tick(); tick();
      addr_ok = 0; ex_flush = 1; ex_entry = 32'h1C008000; br_taken = 1; br_target = 32'h1C000100;
      #1;
      tests++;
      if (discard_out !== 1'b1) begin fails++; $display("FAIL prio_discard: got %b want 1", discard_out); end
      tick();
      ex_flush = 0; br_taken = 0;
      #1;
      tests++;
      if ({discard_out, PC_out, inst_sram_addr} !== {1'b0, 32'h1C008000, 32'h1C008000}) begin
         fails++; $display("FAIL prio_target: got %b/%h/%h want 0/1c008000/1c008000", discard_out, PC_out, inst_sram_addr);
      end
   endtask

   task automatic test_ertn_exc;
      do_reset();
      tick();
      ertn_flush = 1; era = 32'h1C000002;
      #1;
      tests++;
      if ({inst_sram_req, out_valid} !== 2'b00) begin
         fails++; $display("FAIL ertn_flushing: got %b%b want 00", inst_sram_req, out_valid);
      end
      tick();
      ertn_flush = 0;
      #1;
      tests++;
      if ({inst_sram_req, out_valid, has_exception_out, ecode_out, esubcode_out, inst_valid_out, inst_out, PC_out}
          !== {3'b011, 6'h08, 9'h0, 1'b1, 32'h0, 32'h1C000002}) begin
         fails++; $display("FAIL ertn_adef: req%b ov%b ex%b ec%h es%h iv%b inst%h pc%h", inst_sram_req, out_valid,
                           has_exception_out, ecode_out, esubcode_out, inst_valid_out, inst_out, PC_out);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      addr_ok = 1;
      tick(); tick();
      addr_ok = 0; data_ok = 1; rdata = 32'h12345678;
      tick();
      data_ok = 0;
      #2 rst_n = 0;
      #1;
      tests++;
      if (all_out() !== 128'd0) begin fails++; $display("FAIL async_reset: got %h want 0", all_out()); end
      @(negedge clk) rst_n = 1;
      tick();
      tests++;
      if ({inst_sram_req, inst_sram_addr} !== {1'b1, RPC}) begin
         fails++; $display("FAIL restart: got %b/%h want 1/%h", inst_sram_req, inst_sram_addr, RPC);
      end
   endtask

   // Model: the PC, whether its request was accepted, and whether IF holds its data.
   task automatic test_random;
      logic [31:0] m_pc, m_inst, r;
      logic        m_started, m_wait, m_have, f, mis, e_req, e_ov, e_disc, e_iv;
      logic [31:0] e_inst;
      do_reset();
      m_pc = RPC; m_inst = 0; m_started = 0; m_wait = 0; m_have = 0;
      for (int n = 0; n < 3000; n++) begin
         out_ready = ($urandom_range(0, 1) == 0); addr_ok = ($urandom_range(0, 1) == 0);
         data_ok = ($urandom_range(0, 1) == 0); iw_pending = ($urandom_range(0, 3) == 0);
         rdata = $urandom;
         ex_flush = ($urandom_range(0, 19) == 0); ertn_flush = ($urandom_range(0, 19) == 0);
         tlb_flush = ($urandom_range(0, 19) == 0); br_taken = ($urandom_range(0, 9) == 0);
         r = $urandom; ex_entry = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00};
         r = $urandom; era = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00};
         r = $urandom; refetch_pc = {r[31:2], 2'b00};
         r = $urandom; br_target = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00};
         #1;
         f = ex_flush | ertn_flush | tlb_flush | br_taken;
         mis = m_started && (m_pc % 4 != 0);
         e_req = m_started && !mis && !m_wait && !f;
         e_ov = m_started && (mis || m_wait) && !f;
         e_disc = f && m_started && !mis && ((!m_wait && e_req && addr_ok) ||
                  (m_wait && !m_have && !(data_ok && !iw_pending)));
         e_iv = mis || m_have;
         e_inst = mis ? 32'd0 : m_inst;
         tests++;
         if ({inst_sram_req, out_valid, discard_out, inst_valid_out, has_exception_out} !== {e_req, e_ov, e_disc, e_iv, mis} ||
             PC_out !== m_pc || inst_sram_addr !== m_pc || inst_out !== e_inst ||
             ecode_out !== (mis ? 6'h08 : 6'h00) || esubcode_out !== 9'h0) begin
            fails++;
            $display("FAIL random[%0d]: req%b ov%b dis%b iv%b ex%b pc%h inst%h ec%h / want req%b ov%b dis%b iv%b ex%b pc%h inst%h",
                     n, inst_sram_req, out_valid, discard_out, inst_valid_out, has_exception_out, PC_out, inst_out, ecode_out,
                     e_req, e_ov, e_disc, e_iv, mis, m_pc, e_inst);
         end
         @(posedge clk);
         if (!m_started) m_started = 1;
         else if (f) begin
            m_pc = ex_flush ? ex_entry : ertn_flush ? era : tlb_flush ? refetch_pc : br_target;
            m_wait = 0; m_have = 0; m_inst = 0;
         end else if (mis || m_wait) begin
            if (out_ready) begin m_pc = m_pc + 4; m_wait = 0; m_have = 0; m_inst = 0; end
            else if (m_wait && data_ok && !iw_pending && !m_have) begin m_have = 1; m_inst = rdata; end
         end else if (addr_ok) m_wait = 1;
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_capture();
      test_branch_discard();
      test_flush_priority();
      test_ertn_exc();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
